cordic_vector_iter: RTL
=======================

CORDIC_VECTOR_ITER -- requirements
Module: cordic_vector_iter

Interface
REQ-001 SHALL have parameter INTEGER_WIDTH, default 2, input integer bits.
REQ-002 SHALL have parameter FRACTIONAL_WIDTH, default 20, fractional bits of all data.
REQ-003 SHALL have parameter DATA_WIDTH, default INTEGER_WIDTH+FRACTIONAL_WIDTH (22), input width.
REQ-004 SHALL have parameter ITERATIONS, default 16, micro-rotation count.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named as follows.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous reset, active high.
REQ-008 clk_en  input  1  global enable; low freezes all state.
REQ-009 in_valid  input  1  x_in/y_in valid.
REQ-010 in_ready  output  1  block can accept; equals (state==IDLE) AND clk_en.
REQ-011 x_in  input  DATA_WIDTH  signed Q2.20 vector x.
REQ-012 y_in  input  DATA_WIDTH  signed Q2.20 vector y.
REQ-013 out_valid  output  1  results valid.
REQ-014 out_ready  input  1  consumer accepts results.
REQ-015 angle_out  output  DATA_WIDTH+1  signed Q3.20 atan2(y,x), radians, range [-pi, pi].
REQ-016 mag_out  output  DATA_WIDTH+1  unsigned-valued Q3.20 sqrt(x²+y²), gain-compensated.

Function
REQ-017 SHALL implement an FSM with states IDLE, PRE, ITER, SCALE, DONE; no transition or register update occurs on an edge where clk_en=0.
REQ-018 Input transfer on an edge with in_valid & in_ready: capture x_in, y_in sign-extended to DATA_WIDTH+2 internal bits; IDLE->PRE.
REQ-019 PRE: x<0,y>=0 -> (x,y,z)=(y,-x,+pi/2); x<0,y<0 -> (-y,x,-pi/2); else (x,y,0); record zero flag if x=y=0; ->ITER, i=0.
REQ-020 ITER step i: y>=0 -> x+=y>>>i, y-=x>>>i, z+=atan(2^-i); y<0 -> x-=y>>>i, y+=x>>>i, z-=atan(2^-i); all using pre-step x,y; >>> is arithmetic shift.
REQ-021 ITER SHALL run i=0..ITERATIONS-1, one step per enabled edge, then ->SCALE.
REQ-022 SCALE: mag = (x * K) arithmetically shifted right by FRACTIONAL_WIDTH, K = 636750 (0.6072529 in Q0.20), truncated; angle = z; if zero flag, both forced to 0; registered into outputs; ->DONE, out_valid=1.
REQ-023 Latency: out_valid SHALL rise on the 19th enabled rising edge, counting the accepting edge as 1 (ITERATIONS=16).
REQ-024 DONE: angle_out/mag_out held stable while out_valid=1; output transfer on an edge with out_valid & out_ready & clk_en; ->IDLE, out_valid=0.
REQ-025 in_valid while not IDLE SHALL be ignored; no input is accepted on the output-transfer edge.
REQ-026 Accuracy: |angle error| and |mag error| SHALL be ≤ 64 LSB (2^-14) over the full input range, including x_in=-2.0.
REQ-027 clk_en low mid-operation SHALL pause and resume exactly, giving bit-identical results.

Reset
REQ-028 rst asserted SHALL immediately force state=IDLE, i=0, out_valid=0, angle_out=0, mag_out=0, internal x/y/z=0, zero flag=0, regardless of clk or clk_en.
REQ-029 Reset mid-operation SHALL abandon the operation; no out_valid pulse follows.

Structure
REQ-030 Shared package cordic_pkg SHALL hold the width parameters, the atan(2^-i) table in Q3.20 (i=0: 823550, i=1: 486170, i=2: 256879, ...), PI_2=1647099, K=636750, and the state encoding.
REQ-031 One combinational sub-module cordic_vec_step (inputs x, y, z, i, atan_i; outputs next x, y, z) SHALL implement REQ-020; the FSM, counter, and registers stay in cordic_vector_iter.

Verification
REQ-032 (1.0,0) -> angle 0, mag 1048576 ±64, out_valid on edge 19.
REQ-033 (0,1.0) -> angle 1647099; (-1.0,0) -> angle 3294199 (pi); (-1.0,-1.0) -> angle -2470649; all ±64.
REQ-034 (1.0,1.0) -> angle 823550, mag 1482910 ±64; (0,0) -> angle 0, mag 0.
REQ-035 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, extra in_valid ignored; then out_ready=1 -> one transfer, IDLE.
REQ-036 Toggle clk_en low for 5 cycles during ITER -> identical results, latency +5; assert rst at ITER i=7 -> all outputs 0, no out_valid, next input processed correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC vectoring constants: widths, angle table, pi/2, gain correction and FSM encoding.
// All angle constants are Q3.20 radians; K is the inverse CORDIC gain in Q0.20.
package cordic_pkg;

    localparam int CORDIC_INT_W  = 2;
    localparam int CORDIC_FRAC_W = 20;
    localparam int CORDIC_DATA_W = CORDIC_INT_W + CORDIC_FRAC_W;
    localparam int CORDIC_ITERS  = 16;

    localparam int CORDIC_PI_2 = 1647099;
    localparam int CORDIC_K    = 636750;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ITER  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // atan(2^-i) in Q3.20; beyond i=8 the angle equals 2^-i to within rounding.
    function automatic int atan_lut(input int i);
        int r;
        case (i)
            0:       r = 823550;
            1:       r = 486170;
            2:       r = 256879;
            3:       r = 130396;
            4:       r = 65451;
            5:       r = 32757;
            6:       r = 16383;
            7:       r = 8192;
            default: r = (i <= 20) ? (1 << (20 - i)) : 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_vector_iter_if.sv
// Handshake bundle between a vector producer/result consumer (master) and the CORDIC block (slave).
interface cordic_vector_iter_if
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = CORDIC_DATA_W
);
    logic                           clk_en;
    logic                           in_valid;
    logic                           in_ready;
    logic signed [DATA_WIDTH-1:0]   x_in;
    logic signed [DATA_WIDTH-1:0]   y_in;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [DATA_WIDTH:0]     angle_out;
    logic        [DATA_WIDTH:0]     mag_out;

    modport master (
        output clk_en, in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, angle_out, mag_out
    );

    modport slave (
        input  clk_en, in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, angle_out, mag_out
    );
endinterface

// File: rtl/cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation driving y toward zero.
// Both updates use the pre-step x and y; shifts are arithmetic.
module cordic_vec_step #(
    parameter int W  = 24,
    parameter int CW = 5
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic        [CW-1:0] i,
    input  logic signed [W-1:0]  atan_i,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;

    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (!y[W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_i;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_i;
        end
    end
endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring: atan2(y,x) and gain-compensated magnitude, one micro-rotation per enabled clock.
// Result registered on the 19th enabled edge after acceptance; held in DONE until out_ready, clk_en low freezes everything.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int INTEGER_WIDTH    = CORDIC_INT_W,
    parameter int FRACTIONAL_WIDTH = CORDIC_FRAC_W,
    parameter int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH,
    parameter int ITERATIONS       = CORDIC_ITERS
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_vector_iter_if.slave  bus
);
    localparam int W  = DATA_WIDTH + 2;
    localparam int AW = DATA_WIDTH + 1;
    localparam int CW = $clog2(ITERATIONS + 1);
    localparam int PW = W + 22;

    localparam logic signed [PW-1:0] K_EXT  = PW'(CORDIC_K);
    localparam logic        [CW-1:0] LAST_I = CW'(ITERATIONS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [W-1:0]  x_r;
    logic signed [W-1:0]  y_r;
    logic signed [W-1:0]  z_r;
    logic                 zero_r;
    logic                 out_valid_r;
    logic signed [AW-1:0] angle_r;
    logic [AW-1:0]        mag_r;

    logic signed [W-1:0]  x_nx;
    logic signed [W-1:0]  y_nx;
    logic signed [W-1:0]  z_nx;
    logic signed [W-1:0]  atan_i;

    assign atan_i = W'(atan_lut(int'(cnt)));

    cordic_vec_step #(
        .W  (W),
        .CW (CW)
    ) u_step (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .i      (cnt),
        .atan_i (atan_i),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    assign bus.in_ready  = (state == IDLE) && bus.clk_en;
    assign bus.out_valid = out_valid_r;
    assign bus.angle_out = angle_r;
    assign bus.mag_out   = mag_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            angle_r     <= '0;
            mag_r       <= '0;
        end else if (bus.clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r   <= W'(bus.x_in);
                        y_r   <= W'(bus.y_in);
                        state <= PRE;
                    end
                end
                PRE: begin
                    // Fold the left half-plane onto the right so the iterations converge over [-pi, pi].
                    zero_r <= (x_r == '0) && (y_r == '0);
                    if (x_r[W-1] && !y_r[W-1]) begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= W'(CORDIC_PI_2);
                    end else if (x_r[W-1]) begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= -W'(CORDIC_PI_2);
                    end else begin
                        z_r <= '0;
                    end
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    if (cnt == LAST_I) begin
                        cnt   <= '0;
                        state <= SCALE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCALE: begin
                    if (zero_r) begin
                        angle_r <= '0;
                        mag_r   <= '0;
                    end else begin
                        angle_r <= AW'(z_r);
                        mag_r   <= AW'((PW'(x_r) * K_EXT) >>> FRACTIONAL_WIDTH);
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
